// File: rtl/fpu_pkg.sv
// Shared types and constants for the integer-to-float conversion arbiter.
// Holds the FSM encoding, default abort budget and reference IEEE-754 values.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } conv_state_e;

    localparam int TIMEOUT_DEF = 48;

    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_THREE = 32'h4040_0000;
    localparam logic [31:0] FP_2P24  = 32'h4B80_0000;
    localparam logic [31:0] FP_2P32  = 32'h4F80_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int            sum;
    logic [IW-1:0] idx;

    // ptr is always kept below N, so a single wrap subtraction suffices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = IW'(sum);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fpu_conv_arbiter.sv
// Shares one uint32->float32 converter among N_REQ requesters, one job at a time.
// Latency: grant to rsp_valid is converter latency + 2 cycles (abort after TIMEOUT RUN cycles).
// Backpressure: result held in RESP until rsp_ready; no new grant until then.
module fpu_conv_arbiter
    import fpu_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int IW      = $clog2(N_REQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_err,
    output logic [31:0]           conv_a,
    output logic                  conv_en,
    output logic                  conv_rst,
    input  logic                  conv_complete,
    input  logic [31:0]           conv_z
);

    conv_state_e   state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   op_reg_q, op_reg_d;
    logic [IW-1:0] id_reg_q, id_reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rsp_t          rsp_q, rsp_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          conv_en_q, conv_en_d;
    logic          conv_rst_q, conv_rst_d;

    logic [N_REQ-1:0] req_ready_c;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [31:0]      req_words [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_words[i] = req_data[32*i +: 32];
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // conv_en/conv_rst are computed one cycle ahead so they are registered
    // with the state they belong to; the converter idles in reset.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_reg_d    = op_reg_q;
        id_reg_d    = id_reg_q;
        cnt_d       = cnt_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        conv_en_d   = 1'b0;
        conv_rst_d  = 1'b1;
        req_ready_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_grant;
                    op_reg_d    = req_words[arb_idx];
                    id_reg_d    = arb_idx;
                    rr_ptr_d    = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    conv_en_d   = 1'b1;
                    state_d     = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d      = '0;
                conv_en_d  = 1'b1;
                conv_rst_d = 1'b0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (conv_complete) begin
                    rsp_d.data  = conv_z;
                    rsp_d.err   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    rsp_d.data  = '0;
                    rsp_d.err   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    conv_en_d  = 1'b1;
                    conv_rst_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_reg_q    <= '0;
            id_reg_q    <= '0;
            cnt_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            conv_en_q   <= 1'b0;
            conv_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_reg_q    <= op_reg_d;
            id_reg_q    <= id_reg_d;
            cnt_q       <= cnt_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            conv_en_q   <= conv_en_d;
            conv_rst_q  <= conv_rst_d;
        end
    end

    // rsp_id tracks the owner register; it only changes on a new grant,
    // which cannot happen while a response is pending.
    assign req_ready = req_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;
    assign rsp_id    = id_reg_q;
    assign conv_a    = op_reg_q;
    assign conv_en   = conv_en_q;
    assign conv_rst  = conv_rst_q;

endmodule

// File: tb/tb_fpu_conv_arbiter.sv
// Directed bench for fpu_conv_arbiter with a behavioural converter stub.
`timescale 1ns/1ps
module tb_fpu_conv_arbiter;
    import fpu_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            rsp_err;
    logic [31:0]     conv_a;
    logic            conv_en;
    logic            conv_rst;
    logic            conv_complete;
    logic [31:0]     conv_z;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_conv_arbiter #(.N_REQ(N), .TIMEOUT(48)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .rsp_err       (rsp_err),
        .conv_a        (conv_a),
        .conv_en       (conv_en),
        .conv_rst      (conv_rst),
        .conv_complete (conv_complete),
        .conv_z        (conv_z)
    );

    always #5 clk = ~clk;

    // Reference uint32 -> float32 conversion, round to nearest even.
    function automatic logic [31:0] u2f(input logic [31:0] u);
        int          p;
        int          sh;
        logic [31:0] m, rem, half;
        logic [7:0]  e;
        if (u == 32'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (u[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) begin
            m = u << (23 - p);
        end else begin
            sh   = p - 23;
            m    = u >> sh;
            rem  = u & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 32'd1;
            if (m[24]) begin
                m = m >> 1;
                e = e + 8'd1;
            end
        end
        return {1'b0, e, m[22:0]};
    endfunction

    // Converter stub: captures conv_a while held in reset, completes in the
    // stub_lat-th enabled cycle after reset releases, or never if stub_hang.
    int          stub_lat  = 3;
    bit          stub_hang = 1'b0;
    logic [31:0] stub_op   = '0;
    int          stub_cnt  = 0;

    always @(posedge clk) begin
        if (conv_rst) begin
            stub_op  <= conv_a;
            stub_cnt <= 0;
        end else if (conv_en) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign conv_complete = conv_en && !conv_rst && !stub_hang && (stub_cnt == stub_lat - 1);
    assign conv_z        = u2f(stub_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!rsp_valid && n < 200);
    endtask

    task automatic run_job(input string tag, input int slot, input logic [31:0] data,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int n;
        req_data[32*slot +: 32] = data;
        req_valid = N'(1 << slot);
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << slot));
        step();
        req_valid = '0;
        #1;
        chk({tag, "_ready_pulse"}, 32'(req_ready), 32'd0);
        chk({tag, "_clr_rst"}, 32'(conv_rst), 32'd1);
        chk({tag, "_clr_en"}, 32'(conv_en), 32'd1);
        step();
        chk({tag, "_run_rst"}, 32'(conv_rst), 32'd0);
        chk({tag, "_run_en"}, 32'(conv_en), 32'd1);
        chk({tag, "_conv_a"}, conv_a, data);
        wait_rsp(n);
        chk({tag, "_latency"}, 32'(n + 2), 32'(exp_lat));
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_id"}, 32'(rsp_id), 32'(slot));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_resp_en"}, 32'(conv_en), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        int busy;
        int seen;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_conv_en", 32'(conv_en), 32'd0);
        chk("rst_conv_rst", 32'(conv_rst), 32'd1);
        chk("rst_conv_a", conv_a, 32'd0);
        rst = 1'b0;
        step();

        // Single requests, including rounding boundaries and varied latencies.
        stub_lat = 3;
        run_job("one", 0, 32'd1, FP_ONE, 1'b0, 5);
        stub_lat = 1;
        run_job("zero", 2, 32'd0, FP_ZERO, 1'b0, 3);
        stub_lat = 6;
        run_job("max", 3, 32'hFFFF_FFFF, FP_2P32, 1'b0, 8);
        stub_lat = 3;
        run_job("tie", 1, 32'h0100_0001, FP_2P24, 1'b0, 5);

        // Fairness from a fresh pointer, rsp_ready held high throughout.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'd3;
        req_valid = '1;
        rsp_ready = 1'b1;
        busy = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            n = 0;
            while (req_ready == '0 && n < 50) begin
                step();
                #1;
                n++;
            end
            chk("fair_grant", 32'(req_ready), 32'(1 << (j % N)));
            n = 0;
            do begin
                step();
                n++;
                if (req_ready != '0) busy++;
            end while (!rsp_valid && n < 200);
            chk("fair_data", rsp_data, FP_THREE);
            chk("fair_id", 32'(rsp_id), 32'(j % N));
            step();
            chk("fair_drop", 32'(rsp_valid), 32'd0);
        end
        chk("fair_busy_ready", 32'(busy), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b0;
        step();

        // Backpressure: pointer now 1, hold the response for 10 cycles.
        req_data[32 +: 32] = 32'd1;
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        wait_rsp(n);
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, FP_ONE);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("bp_drop", 32'(rsp_valid), 32'd0);
        chk("bp_idle_grant", 32'(req_ready), 32'h4);
        req_valid = '0;
        #1;
        chk("bp_withdrawn", 32'(req_ready), 32'd0);
        step();
        chk("bp_no_job_en", 32'(conv_en), 32'd0);
        chk("bp_no_job_rst", 32'(conv_rst), 32'd1);

        // Timeout: converter never completes; 48 RUN cycles then error.
        stub_hang = 1'b1;
        run_job("tmo", 2, 32'd5, FP_ZERO, 1'b1, 50);

        // Reset in the middle of RUN discards the job.
        req_data[96 +: 32] = 32'd7;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        for (int c = 0; c < 5; c++) step();
        chk("mid_in_run", 32'(conv_en), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_data", rsp_data, 32'd0);
        chk("mid_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_conv_en", 32'(conv_en), 32'd0);
        chk("mid_conv_rst", 32'(conv_rst), 32'd1);
        chk("mid_conv_a", conv_a, 32'd0);
        rst       = 1'b0;
        stub_hang = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        run_job("after", 0, 32'd1, FP_ONE, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_conv_arbiter.md
FPU_CONV_ARBITER -- requirements
Module: fpu_conv_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, 48, max cycles allowed in RUN before abort.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  N_REQ  per-requester conversion request.
REQ-006 req_data  in  32*N_REQ  per-requester unsigned integer operand, slot i at bits [32i+31:32i].
REQ-007 req_ready  out  N_REQ  one-hot acceptance pulse.
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  consumer accepts result.
REQ-010 rsp_data  out  32  IEEE-754 single result, or 0 on error.
REQ-011 rsp_id  out  clog2(N_REQ)  index of the requester that owns the result.
REQ-012 rsp_err  out  1  conversion timed out.
REQ-013 conv_a  out  32  operand to the shared converter.
REQ-014 conv_en  out  1  converter enable.
REQ-015 conv_rst  out  1  converter synchronous reset.
REQ-016 conv_complete  in  1  converter done flag.
REQ-017 conv_z  in  32  converter result.

Function
REQ-018 The FSM SHALL have states IDLE, CLR, RUN, RESP.
REQ-019 IDLE: if any req_valid, grant the lowest index at or after rr_ptr (wrapping), pulse req_ready[g] for exactly one cycle, latch req_data[g] into op_reg and g into id_reg, go to CLR; otherwise stay.
REQ-020 The grant SHALL update rr_ptr to (g+1) mod N_REQ, so a requester that holds valid is granted within N_REQ grants.
REQ-021 CLR: one cycle with conv_rst=1 and conv_en=1, forcing the converter to its operand-capture state; go to RUN.
REQ-022 RUN: conv_en=1, conv_rst=0, conv_a=op_reg throughout; clear the timeout counter on entry and increment it each cycle.
REQ-023 RUN: on conv_complete=1, latch conv_z into rsp_data, set rsp_err=0, and go to RESP.
REQ-024 RUN: if the counter reaches TIMEOUT before conv_complete, set rsp_data=0 and rsp_err=1, and go to RESP.
REQ-025 RESP: conv_en=0, rsp_valid=1, rsp_data/rsp_id/rsp_err stable; on rsp_ready=1, drop rsp_valid the next cycle and return to IDLE.
REQ-026 conv_a SHALL equal op_reg in every state; conv_en SHALL be 0 in IDLE and RESP.
REQ-027 req_ready SHALL be 0 outside IDLE; no new request is accepted while a job is in flight (single outstanding job).
REQ-028 A req_valid that drops before its grant SHALL be ignored, without error.
REQ-029 rsp_ready asserted outside RESP SHALL have no effect.
REQ-030 Turnaround from grant to rsp_valid SHALL be converter latency + 2 cycles.

Reset
REQ-031 On rst: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, conv_en=0, conv_rst=1, counter=0, op_reg=0.
REQ-032 rst mid-job SHALL discard the job silently, with no response issued.

Structure
REQ-033 The FSM state encoding, TIMEOUT default and the IEEE-754 constants used by the bench SHALL reside in shared package fpu_pkg.
REQ-034 The round-robin grant logic SHALL be a sub-module, rr_arbiter (inputs req, ptr; outputs grant one-hot, grant_idx, any).

Verification
REQ-035 Single request: req 0 data 1 -> req_ready[0] pulse, conv_rst pulse, rsp_data 0x3F800000, rsp_id 0, rsp_err 0.
REQ-036 Boundaries: data 0 -> 0x00000000; 0xFFFFFFFF -> 0x4F800000; 0x01000001 -> 0x4B800000 (tie to even).
REQ-037 Fairness: all four valid continuously with data 3 -> grants in order 0,1,2,3,0; every rsp_data is 0x40400000.
REQ-038 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data and rsp_id stable, no req_ready pulse; then released -> IDLE.
REQ-039 Timeout: converter stub never raises conv_complete -> after 48 RUN cycles, rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-040 rst asserted during RUN -> all outputs at reset values next cycle, and no rsp_valid afterwards.
